v_divide_seq: RTL and testbench

Sequential unsigned restoring divider. Splits a 2*WIDTH-bit dividend (the width produced by the team's multiply/accumulate blocks) by a WIDTH-bit divisor, producing one quotient bit per clock. It is the inverse-direction arithmetic block to the MAC family. Control uses a start/busy/done handshake, so it can sit behind an accumulator or a register file without stalling a pipeline.

---
 rtl/v_divide_seq.sv | 132 +++++++++++++
 tb/tb_v_divide_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/v_divide_seq.sv
// v_divide_seq -- sequential unsigned restoring divider.
//
// Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor, retiring one
// quotient bit per clock (2*WIDTH cycles per operation). Control is a
// start/busy/done handshake; a zero divisor completes in one cycle with
// the dbz flag set instead of running the iteration loop.
//
// Ports:
//   clk       clock, all logic on posedge
//   rst       synchronous, active-high reset
//   start     request, sampled only while idle
//   DIVIDEND  [2*WIDTH-1:0] unsigned dividend, captured on accepted start
//   DIVISOR   [WIDTH-1:0]   unsigned divisor, captured on accepted start
//   QUO       [2*WIDTH-1:0] registered quotient (all ones on divide-by-zero)
//   REM       [WIDTH-1:0]   registered remainder
//   busy      high while an operation is in progress
//   done      single-cycle completion pulse
//   dbz       divide-by-zero flag of the most recent completed operation
module v_divide_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   DIVIDEND,
  input  logic [WIDTH-1:0]     DIVISOR,
  output logic [2*WIDTH-1:0]   QUO,
  output logic [WIDTH-1:0]     REM,
  output logic                 busy,
  output logic                 done,
  output logic                 dbz
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt;
  // Dividend bits leave at the top while quotient bits enter at the bottom,
  // so after DW shifts this register holds the full quotient.
  logic [DW-1:0]     dq_sr;
  logic [WIDTH-1:0]  dvs;
  logic [WIDTH-1:0]  p;
  logic [WIDTH:0]    p_shift;
  logic [WIDTH-1:0]  p_next;
  logic              q_bit;
  logic              last;

  assign last = (state == RUN) && (cnt == CW'(DW - 1));
  assign busy = (state == RUN);

  // One restoring step. The shifted partial remainder needs WIDTH+1 bits so
  // the compare cannot overflow; the difference, when taken, is always
  // smaller than the divisor, so WIDTH bits of it are exact.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    q_bit   = 1'b0;
    p_shift = {p, dq_sr[DW-1]};
    p_next  = p_shift[WIDTH-1:0];
    if (p_shift >= {1'b0, dvs}) begin
      q_bit  = 1'b1;
      p_next = p_shift[WIDTH-1:0] - dvs;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && (DIVISOR != '0)) state_next = RUN;
      RUN:     if (last)                     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      dq_sr <= '0;
      dvs   <= '0;
      p     <= '0;
      QUO   <= '0;
      REM   <= '0;
      done  <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (DIVISOR == '0) begin
              QUO  <= '1;
              REM  <= '0;
              dbz  <= 1'b1;
              done <= 1'b1;
            end else begin
              dq_sr <= DIVIDEND;
              dvs   <= DIVISOR;
              p     <= '0;
              cnt   <= '0;
            end
          end
        end
        RUN: begin
          dq_sr <= {dq_sr[DW-2:0], q_bit};
          p     <= p_next;
          cnt   <= cnt + CW'(1);
          if (last) begin
            QUO  <= {dq_sr[DW-2:0], q_bit};
            REM  <= p_next;
            dbz  <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_v_divide_seq.sv
// tb_v_divide_seq -- self-checking bench for v_divide_seq (WIDTH=8).
// Expected quotient/remainder come from plain integer division; timing
// expectations come from the handshake rules (16-cycle latency, 1-cycle
// divide-by-zero, single-cycle done).
module tb_v_divide_seq;

  localparam int WIDTH = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [2*WIDTH-1:0]  dividend;
  logic [WIDTH-1:0]    divisor;
  logic [2*WIDTH-1:0]  quo;
  logic [WIDTH-1:0]    rem;
  logic                busy;
  logic                done;
  logic                dbz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  v_divide_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .DIVIDEND (dividend),
    .DIVISOR  (divisor),
    .QUO      (quo),
    .REM      (rem),
    .busy     (busy),
    .done     (done),
    .dbz      (dbz)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance until done is seen or max edges pass. Reports edges taken,
  // observations with busy high, and whether QUO/REM stayed put meanwhile.
  task automatic wait_done(input int max, output int n, output int busy_n, output bit stable);
    logic [2*WIDTH-1:0] q0;
    logic [WIDTH-1:0]   r0;
    q0 = quo;
    r0 = rem;
    n = 0;
    busy_n = 0;
    stable = 1'b1;
    while (!done && n < max) begin
      if (busy) busy_n++;
      if (quo !== q0 || rem !== r0) stable = 1'b0;
      tick();
      n++;
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input string tag);
    logic [15:0] exp_q;
    logic [7:0]  exp_r;
    logic [31:0] recon;
    int n, bn;
    bit st;
    exp_q = (b == 0) ? 16'hFFFF : a / b;
    exp_r = (b == 0) ? 8'd0 : 8'(a % b);
    start = 1'b1;
    dividend = a;
    divisor = b;
    tick();
    start = 1'b0;
    dividend = 16'($urandom);
    divisor = 8'($urandom);
    if (b == 0) begin
      check({tag, "_dbz_done"}, done, 1);
      check({tag, "_dbz_busy"}, busy, 0);
      check({tag, "_dbz_flag"}, dbz, 1);
    end else begin
      check({tag, "_busy_after_accept"}, busy, 1);
      wait_done(40, n, bn, st);
      check({tag, "_latency"}, n, 16);
      check({tag, "_busy_cycles"}, bn, 16);
      check({tag, "_stable_midop"}, st, 1);
      check({tag, "_dbz_clear"}, dbz, 0);
      recon = 32'(quo) * 32'(b) + 32'(rem);
      check({tag, "_invariant"}, recon, 32'(a));
      check({tag, "_rem_lt_div"}, rem < b, 1);
      check({tag, "_busy_at_done"}, busy, 0);
    end
    check({tag, "_quo"}, quo, exp_q);
    check({tag, "_rem"}, rem, exp_r);
    tick();
    check({tag, "_done_single"}, done, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bn, n_acc, dcount;
    bit st;
    logic [15:0] a;
    logic [7:0]  b;

    // Reset with random inputs (start possibly high): rst must win.
    rst = 1'b1;
    start = 1'($urandom);
    dividend = 16'($urandom);
    divisor = 8'($urandom);
    repeat (2) tick();
    check("reset_quo", quo, 0);
    check("reset_rem", rem, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_dbz", dbz, 0);
    rst = 1'b0;
    start = 1'b0;
    tick();

    run_op(16'd1000, 8'd7, "d1000_7");

    // Extremes.
    run_op(16'd65535, 8'd255, "d65535_255");
    run_op(16'd65535, 8'd1, "d65535_1");
    run_op(16'd5, 8'd9, "d5_9");
    run_op(16'd0, 8'd3, "d0_3");

    // Divide by zero, then a normal op clears dbz.
    run_op(16'd1234, 8'd0, "d1234_0");
    run_op(16'd100, 8'd10, "d100_10");

    // Start pulsed during RUN is ignored.
    start = 1'b1;
    dividend = 16'd1000;
    divisor = 8'd7;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    dividend = 16'd300;
    divisor = 8'd7;
    tick();
    start = 1'b0;
    wait_done(40, n, bn, st);
    check("ignore_latency", n + 5, 16);
    check("ignore_quo", quo, 142);
    check("ignore_rem", rem, 6);
    // Start held high in the done cycle is accepted on the next edge.
    start = 1'b1;
    dividend = 16'd300;
    divisor = 8'd7;
    tick();
    start = 1'b0;
    check("b2b_busy", busy, 1);
    wait_done(40, n, bn, st);
    check("b2b_spacing", n + 1, 17);
    check("b2b_quo", quo, 42);
    check("b2b_rem", rem, 6);
    tick();
    check("b2b_done_single", done, 0);

    // Reset in the middle of an operation, with start also high.
    start = 1'b1;
    dividend = 16'd1000;
    divisor = 8'd7;
    tick();
    start = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    start = 1'b1;
    dividend = 16'($urandom);
    divisor = 8'($urandom);
    tick();
    check("midrst_quo", quo, 0);
    check("midrst_rem", rem, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_dbz", dbz, 0);
    rst = 1'b0;
    start = 1'b0;
    dcount = 0;
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) dcount++;
      if (busy) n_acc++;
      tick();
    end
    check("midrst_no_done", dcount, 0);
    check("midrst_no_busy", n_acc, 0);
    run_op(16'd50000, 8'd123, "d50000_123");

    // Random regression with occasional zero and small divisors.
    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 15))
        0:       b = 8'd0;
        1, 2:    b = 8'($urandom_range(1, 3));
        default: b = 8'($urandom);
      endcase
      run_op(a, b, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
